// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU.
//   - 3-bit opcode encodings (AND, OR, ADD, SUB; all other codes are invalid)
//   - FSM state type for the bit_serial_alu sequencer
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bit_serial_alu_bitalu.sv
// BitALU: 1-bit combinational ALU slice.
//   a, b  : operand bits
//   cin   : carry in (for SUB the caller supplies 1 on the LSB)
//   op    : opcode (alu_pkg encodings)
//   res   : result bit (0 for invalid opcodes)
//   cout  : carry out (0 for logic and invalid opcodes)
module BitALU
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    res   = 1'b0;
    cout  = 1'b0;
    // SUB is a + ~b + 1; the +1 arrives through cin on the first bit
    b_eff = b ^ (op == OP_SUB);
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD,
      OP_SUB: begin
        res  = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (cin & (a ^ b_eff));
      end
      default: begin
        res  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: WIDTH-bit ALU evaluated one bit per clock, LSB first,
// through a single BitALU slice.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   a, b, op              : operands and opcode, sampled on the accept edge
//   out_valid / out_ready : result handshake (valid only in DONE)
//   result, carry_out, overflow, zero : registered result and flags,
//                           held until the next completion
module bit_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 earlier result bits; the last bit is merged straight
  // from the slice on the final edge, so no extra flop is needed.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic [2:0]       op_r_q, op_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_r_q, carry_r_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] res_full;

  BitALU u_bitalu (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_r_q),
    .op   (op_r_q),
    .res  (slice_res),
    .cout (slice_cout)
  );

  assign res_full = {slice_res, res_sh_q};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    op_r_d      = op_r_q;
    cnt_d       = cnt_q;
    carry_r_d   = carry_r_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          op_r_d    = op;
          cnt_d     = '0;
          carry_r_d = (op == OP_SUB);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        res_sh_d  = res_full[WIDTH-1:1];
        carry_r_d = slice_cout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d       = cnt_q;
          // carry into MSB differs from carry out of MSB -> signed overflow
          overflow_d  = is_arith(op_r_q) ? (carry_r_q ^ slice_cout) : 1'b0;
          carry_out_d = slice_cout;
          result_d    = res_full;
          zero_d      = (res_full == '0);
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      op_r_q      <= '0;
      cnt_q       <= '0;
      carry_r_q   <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      op_r_q      <= op_r_d;
      cnt_q       <= cnt_d;
      carry_r_q   <= carry_r_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: scoreboard-based bench for bit_serial_alu (WIDTH=8).
module tb_bit_serial_alu;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  bit_serial_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Independent reference: whole-word arithmetic, not bit-serial.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [2:0] o);
    exp_t e;
    logic [WIDTH:0] s;
    e = '0;
    case (o)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[WIDTH-1:0];
        e.c = s[WIDTH];
        e.v = (x[WIDTH-1] == y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
      end
      3'b011: begin
        s = {1'b0, x} + {1'b0, ~y} + 1'b1;
        e.res = s[WIDTH-1:0];
        e.c = s[WIDTH];
        e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Accept one op, verify latency, compare against scoreboard, apply
  // hold_cycles of backpressure (with an ignored in_valid pulse), then drain.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [2:0] o, input int hold_cycles, input string name);
    exp_t e;
    exp_t got;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    a = x; b = y; op = o; in_valid = 1'b1;
    sb.push_back(model(x, y, o));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // scramble inputs so a design that keeps reading them is caught
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = 3'($urandom);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (n != WIDTH || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (out_valid=%b) want %0d", name, n, out_valid, WIDTH);
    end
    e = sb.pop_front();
    got = '{res: result, c: carry_out, v: overflow, z: zero};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s result: got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
               name, got.res, got.c, got.v, got.z, e.res, e.c, e.v, e.z);
    end
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      a = 8'hAA; b = 8'h55; op = 3'b010;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      got = '{res: result, c: carry_out, v: overflow, z: zero};
      checks++;
      if (got !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got res=%h c=%b v=%b z=%b ov=%b ir=%b want res=%h ov=1 ir=0",
                 name, k, got.res, got.c, got.v, got.z, out_valid, in_ready, e.res);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    got = '{res: result, c: carry_out, v: overflow, z: zero};
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL %s drain: got ov=%b ir=%b res=%h want ov=0 ir=1 res=%h",
               name, out_valid, in_ready, got.res, e.res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0 ||
        out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got res=%h c=%b v=%b z=%b ov=%b want all 0",
               result, carry_out, overflow, zero, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_arith();
    run_op(8'h7F, 8'h01, 3'b010, 0, "add_7f_01");
    run_op(8'h05, 8'h05, 3'b011, 0, "sub_05_05");
    run_op(8'h00, 8'h01, 3'b011, 0, "sub_00_01");
    run_op(8'h80, 8'h80, 3'b010, 0, "add_80_80");
    run_op(8'h80, 8'h01, 3'b011, 0, "sub_80_01");
  endtask

  task automatic test_logic_invalid();
    run_op(8'hF0, 8'h3C, 3'b000, 0, "and_f0_3c");
    run_op(8'hF0, 8'h3C, 3'b001, 0, "or_f0_3c");
    run_op(8'hFF, 8'hFF, 3'b111, 0, "inv_111");
    run_op(8'h12, 8'h34, 3'b100, 0, "inv_100");
  endtask

  task automatic test_backpressure();
    run_op(8'h3A, 8'h19, 3'b011, 5, "bp_sub");
    run_op(8'h11, 8'h22, 3'b010, 0, "bp_next");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; op = 3'b010; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || carry_out !== 1'b0 ||
        overflow !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got ov=%b ir=%b res=%h c=%b v=%b z=%b want ov=0 ir=1 rest 0",
               out_valid, in_ready, result, carry_out, overflow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_valid%0d: got out_valid=%b want 0", k, out_valid);
      end
    end
    run_op(8'h10, 8'h20, 3'b010, 0, "rst_after_add");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 4)), 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_invalid();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
